// File: rtl/tx_symbol_upsampler.sv
// rtl/tx_symbol_upsampler.sv - 4-ASK symbol FIFO, level mapper and OSR upsampler feeding the SRRC filter
//
// Buffers Gray-coded 4-ASK symbols in a 2-entry FIFO and emits one 18-bit
// signed 1s17 sample per clock: the mapped level in the symbol slot
// (phase 0), zeros in the remaining OSR-1 phases.
//
// Build option: define TX_SYMBOL_UPSAMPLER_HOLD_EN to hold the last popped
// level across all OSR phases (sample-and-hold) instead of inserting zeros.
//
// Ports:
//   clk         in   system clock, one output sample per cycle
//   reset       in   synchronous, active-high
//   sym_in      in   [1:0] Gray-coded symbol
//   sym_valid   in   sym_in valid this cycle
//   sym_ready   out  FIFO can accept (decoded from registered count only)
//   out         out  [17:0] signed 1s17 upsampled sample
//   sym_strobe  out  high when out carries a symbol slot (level or underflow zero)
//   underflow   out  sticky; a symbol slot found the FIFO empty
module tx_symbol_upsampler #(
  parameter int OSR = 4,
  parameter int AMP = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  output logic [17:0] out,
  output logic        sym_strobe,
  output logic        underflow
);

  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);
  localparam logic [17:0] LVL_IN  = 18'(AMP);
  localparam logic [17:0] LVL_OUT = 18'(3 * AMP);

  logic [PW-1:0] ph_q, ph_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    mem_q [2];
  logic [17:0]   out_q, out_d;
  logic          strobe_q, strobe_d;
  logic          uf_q, uf_d;

  logic slot;
  logic push;
  logic pop;

  // Gray map: adjacent levels differ in one bit.
  function automatic logic [17:0] map_sym(input logic [1:0] s);
    logic [17:0] lvl;
    case (s)
      2'b00:   lvl = -LVL_OUT;
      2'b01:   lvl = -LVL_IN;
      2'b11:   lvl = LVL_IN;
      default: lvl = LVL_OUT;
    endcase
    return lvl;
  endfunction

  // Ready depends on registered count only, so there is no path from sym_valid.
  assign sym_ready = ~cnt_q[1];

  always_comb begin
    ph_d     = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
    slot     = (ph_q == '0);
    push     = sym_valid && sym_ready;
    // The pop decision uses the pre-push count: a symbol written this cycle
    // is not visible to the slot in the same cycle.
    pop      = slot && (cnt_q != 2'd0);
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    strobe_d = slot;
    uf_d     = uf_q | (slot && (cnt_q == 2'd0));
    if (pop) begin
      out_d = map_sym(mem_q[rd_ptr_q]);
    end else if (slot) begin
      out_d = '0;
    end else begin
`ifdef TX_SYMBOL_UPSAMPLER_HOLD_EN
      out_d = out_q;
`else
      out_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q     <= '0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      out_q    <= '0;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= sym_in;
    end
  end

  assign out        = out_q;
  assign sym_strobe = strobe_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_tx_symbol_upsampler.sv
// tb/tb_tx_symbol_upsampler.sv - scoreboard bench for tx_symbol_upsampler
module tb_tx_symbol_upsampler;

  localparam int OSR = 4;
  localparam int AMP = 32768;

  logic        clk;
  logic        reset;
  logic [1:0]  sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic [17:0] out;
  logic        sym_strobe;
  logic        underflow;

  tx_symbol_upsampler #(.OSR(OSR), .AMP(AMP)) dut (
    .clk        (clk),
    .reset      (reset),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .out        (out),
    .sym_strobe (sym_strobe),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state
  int   sb[$];
  int   ph_m = 0;
  int   count_m = 0;
  int   last_m = 0;
  logic exp_strobe = 1'b0;
  logic exp_data = 1'b0;
  logic exp_uf = 1'b0;
  logic accepted = 1'b0;

  function automatic int lvl(input logic [1:0] s);
    int v;
    case (s)
      2'b00:   v = -3 * AMP;
      2'b01:   v = -AMP;
      2'b11:   v = AMP;
      default: v = 3 * AMP;
    endcase
    return v;
  endfunction

  // Advance one clock and update the model; outputs are sampled #1 after the edge.
  task automatic tick();
    logic acc;
    logic slot;
    logic popm;
    if (reset) begin
      @(posedge clk); #1;
      ph_m = 0; count_m = 0; sb.delete();
      exp_strobe = 1'b0; exp_data = 1'b0; exp_uf = 1'b0; last_m = 0; accepted = 1'b0;
    end else begin
      acc  = sym_valid && (count_m < 2);
      slot = (ph_m == 0);
      popm = slot && (count_m != 0);
      if (acc) sb.push_back(lvl(sym_in));
      @(posedge clk); #1;
      accepted   = acc;
      exp_strobe = slot;
      exp_data   = popm;
      if (slot && !popm) exp_uf = 1'b1;
      count_m = count_m + int'(acc) - int'(popm);
      ph_m = (ph_m == OSR - 1) ? 0 : ph_m + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sym_valid = 1'b0; sym_in = 2'b00;
    tick(); tick();
    checks++; if (out !== 18'd0) $display("FAIL reset_out: got %0d expected 0", $signed(out)); else passed++;
    checks++; if (sym_strobe !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", sym_strobe); else passed++;
    checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else passed++;
    checks++; if (sym_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", sym_ready); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int got;
    sym_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      got = $signed(out);
      checks++; if (got !== 0) $display("FAIL idle_out c%0d: got %0d expected 0", i, got); else passed++;
      checks++; if (sym_strobe !== exp_strobe) $display("FAIL idle_strobe c%0d: got %b expected %b", i, sym_strobe, exp_strobe); else passed++;
      checks++; if (sym_strobe !== ((i % OSR) == 0)) $display("FAIL idle_strobe_period c%0d: got %b", i, sym_strobe); else passed++;
      checks++; if (underflow !== 1'b1) $display("FAIL idle_underflow c%0d: got %b expected 1", i, underflow); else passed++;
      checks++; if (sym_ready !== 1'b1) $display("FAIL idle_ready c%0d: got %b expected 1", i, sym_ready); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    int idx;
    int got;
    int e;
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    reset = 1'b1; tick(); reset = 1'b0;
    idx = 0; sym_valid = 1'b1; sym_in = seq[0];
    for (int i = 0; i < 22; i++) begin
      tick();
      if (accepted) begin
        idx++;
        if (idx == 2) begin
          checks++; if (sym_ready !== 1'b0) $display("FAIL b2b_ready_drop: got %b expected 0", sym_ready); else passed++;
        end
        if (idx < 4) sym_in = seq[idx];
        else sym_valid = 1'b0;
      end
      got = $signed(out);
      if (exp_data) begin e = sb.pop_front(); last_m = e; end
      else if (exp_strobe) begin e = 0; last_m = 0; end
`ifdef TX_SYMBOL_UPSAMPLER_HOLD_EN
      else e = last_m;
`else
      else e = 0;
`endif
      checks++; if (got !== e) $display("FAIL b2b_out c%0d: got %0d expected %0d", i, got, e); else passed++;
      checks++; if (sym_strobe !== exp_strobe) $display("FAIL b2b_strobe c%0d: got %b expected %b", i, sym_strobe, exp_strobe); else passed++;
      checks++; if (sym_ready !== (count_m < 2)) $display("FAIL b2b_ready c%0d: got %b expected %b", i, sym_ready, count_m < 2); else passed++;
      checks++; if (underflow !== exp_uf) $display("FAIL b2b_underflow c%0d: got %b expected %b", i, underflow, exp_uf); else passed++;
    end
    checks++; if (sb.size() != 0 || idx != 4) $display("FAIL b2b_drain: left %0d pushed %0d expected 0/4", sb.size(), idx); else passed++;
  endtask

  task automatic test_ph0_push();
    int got;
    reset = 1'b1; tick(); reset = 1'b0;
    // The first post-reset edge is a ph==0 slot with the FIFO empty.
    sym_valid = 1'b1; sym_in = 2'b11;
    tick();
    sym_valid = 1'b0;
    got = $signed(out);
    checks++; if (got !== 0 || sym_strobe !== 1'b1) $display("FAIL ph0_slot: got out %0d strobe %b expected 0/1", got, sym_strobe); else passed++;
    checks++; if (underflow !== 1'b1) $display("FAIL ph0_underflow: got %b expected 1", underflow); else passed++;
    for (int i = 1; i <= OSR; i++) begin
      tick();
      got = $signed(out);
      if (i == OSR) begin
        checks++; if (got !== AMP || sym_strobe !== 1'b1) $display("FAIL ph0_next_slot: got out %0d strobe %b expected %0d/1", got, sym_strobe, AMP); else passed++;
        if (exp_data) void'(sb.pop_front());
      end else if (got !== 0) begin
        checks++; $display("FAIL ph0_gap c%0d: got %0d expected 0", i, got);
      end
    end
  endtask

  task automatic test_full_pop();
    int got;
    int e;
    reset = 1'b1; tick(); reset = 1'b0;
    sym_valid = 1'b1; sym_in = 2'($urandom_range(0, 3));
    for (int i = 0; i < 40; i++) begin
      tick();
      if (accepted) sym_in = 2'($urandom_range(0, 3));
      got = $signed(out);
      if (exp_data) begin e = sb.pop_front(); last_m = e; end
      else if (exp_strobe) begin e = 0; last_m = 0; end
`ifdef TX_SYMBOL_UPSAMPLER_HOLD_EN
      else e = last_m;
`else
      else e = 0;
`endif
      checks++; if (got !== e) $display("FAIL full_out c%0d: got %0d expected %0d", i, got, e); else passed++;
      checks++; if (sym_ready !== (count_m < 2)) $display("FAIL full_ready c%0d: got %b expected %b", i, sym_ready, count_m < 2); else passed++;
      checks++; if (sym_strobe !== exp_strobe) $display("FAIL full_strobe c%0d: got %b expected %b", i, sym_strobe, exp_strobe); else passed++;
      checks++; if (underflow !== exp_uf) $display("FAIL full_underflow c%0d: got %b expected %b", i, underflow, exp_uf); else passed++;
    end
    checks++; if (count_m != 2) $display("FAIL full_level: model count %0d expected 2", count_m); else passed++;
  endtask

  task automatic test_reset_mid();
    int got;
    // Continues from a full FIFO left by test_full_pop.
    reset = 1'b1; sym_valid = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (out !== 18'd0 || underflow !== 1'b0) $display("FAIL mid_reset: got out %0d underflow %b expected 0/0", $signed(out), underflow); else passed++;
    checks++; if (sym_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b expected 1", sym_ready); else passed++;
    for (int i = 0; i < 10; i++) begin
      tick();
      got = $signed(out);
      checks++; if (got !== 0) $display("FAIL mid_stale c%0d: got %0d expected 0", i, got); else passed++;
      checks++; if (underflow !== exp_uf) $display("FAIL mid_underflow c%0d: got %b expected %b", i, underflow, exp_uf); else passed++;
    end
  endtask

`ifdef TX_SYMBOL_UPSAMPLER_HOLD_EN
  task automatic test_hold();
    int got;
    int n_hi;
    int n_lo;
    reset = 1'b1; tick(); reset = 1'b0;
    n_hi = 0; n_lo = 0;
    sym_valid = 1'b1; sym_in = 2'b10;
    tick(); sym_in = 2'b01;
    tick(); sym_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      got = $signed(out);
      if (got == 3 * AMP) n_hi++;
      if (got == -AMP) n_lo++;
    end
    checks++; if (n_hi != OSR) $display("FAIL hold_hi: got %0d cycles expected %0d", n_hi, OSR); else passed++;
    checks++; if (n_lo != OSR) $display("FAIL hold_lo: got %0d cycles expected %0d", n_lo, OSR); else passed++;
  endtask
`endif

  initial begin
    reset = 1'b1; sym_valid = 1'b0; sym_in = 2'b00;
    test_reset();
    test_idle();
    test_back_to_back();
    test_ph0_push();
    test_full_pop();
    test_reset_mid();
`ifdef TX_SYMBOL_UPSAMPLER_HOLD_EN
    test_hold();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tx_symbol_upsampler.md
Name: tx_symbol_upsampler

Overview:
- Upstream feeder of the 17-tap SRRC transmit filter.
- Accepts 2-bit Gray-coded 4-ASK symbols over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Maps each symbol to an 18-bit signed 1s17 amplitude.
- Upsamples by OSR using zero insertion: one level sample, then OSR-1 zeros. This produces the filter's per-clock input sample.

Parameters:
- OSR, 4, clocks per symbol (sample/symbol ratio); legal range 2..16.
- AMP, 32768, inner level magnitude in 1s17 (0.25); outer level is 3*AMP; legal range 1..43690 so that 3*AMP fits in 18-bit signed.

Ports:
- clk  in  1  system clock, sample rate
- reset  in  1  synchronous, active-high
- sym_in  in  2  Gray-coded symbol
- sym_valid  in  1  sym_in valid this cycle
- sym_ready  out  1  FIFO can accept; transfer when sym_valid && sym_ready
- out  out  18  signed 1s17 upsampled sample to SRRC filter
- sym_strobe  out  1  high in the cycle where out carries a symbol slot (level or underflow zero)
- underflow  out  1  sticky; set when a symbol slot finds the FIFO empty

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled on a clk edge) sets the following:
  - phase counter ph = 0
  - FIFO count = 0, pointers = 0
  - out = 0, sym_strobe = 0, underflow = 0
  - reset mid-operation discards buffered symbols; no partial-symbol recovery.
- Phase counter: ph <= (ph == OSR-1) ? 0 : ph+1, free-running from the first non-reset cycle. Counter width is clog2(OSR).
- Symbol map (sym_in -> level):
  - 00 -> -3*AMP
  - 01 -> -AMP
  - 11 -> +AMP
  - 10 -> +3*AMP
  - Arithmetic is 18-bit signed; no saturation is needed within the legal AMP range.
- FIFO: 2 entries of 2 bits each.
  - sym_ready = (count < 2), decoded combinationally from registered count only; no combinational path from sym_valid.
  - push = sym_valid && sym_ready.
  - pop = (ph == 0) && (count != 0).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push while full is impossible by construction (ready low).
  - A symbol written in a cycle is not poppable in that same cycle; there is no bypass.
- Output register, updated every clk:
  - ph == 0 and count != 0: out <= map(head), sym_strobe <= 1.
  - ph == 0 and count == 0: out <= 0, sym_strobe <= 1, underflow <= 1 (sticky until reset).
  - ph != 0: out <= 0, sym_strobe <= 0.
- Latency: a symbol pushed into an empty FIFO at cycle t appears on out in the cycle after the first edge with ph == 0 at or after t+1. Minimum latency is 2 clocks.
- Throughput: 1 symbol per OSR clocks. The FIFO absorbs up to 2 symbols of source jitter.
- Steady state: a source that pushes once per OSR clocks sees sym_ready permanently high after the first slot.

Optional Feature:
- Macro: TX_SYMBOL_UPSAMPLER_HOLD_EN.
- Defined: sample-and-hold upsampling.
  - out holds the most recently popped level for all OSR phases instead of inserting zeros.
  - On underflow, out holds 0 for that symbol period.
  - sym_strobe and underflow behaviour are unchanged.
- Undefined: zero insertion as specified above.
- Reset value of out is 0 in both builds.

Test Plan:
- Reset, then hold sym_valid = 0 for 12 clocks -> out = 0 throughout; sym_strobe pulses every 4th clock starting at the first post-reset ph=0 edge; underflow = 1 after the first strobe; sym_ready = 1.
- Reset, then push 10, 11, 01, 00 back-to-back with sym_valid held high -> sym_ready drops after 2 pushes; out sequence is +98304, 0, 0, 0, +32768, 0, 0, 0, -32768, 0, 0, 0, -98304, 0, 0, 0 at strobes; no underflow after the first slot is filled.
- Push a symbol exactly in a cycle where ph == 0 with the FIFO empty -> that slot outputs 0 and sets underflow; the symbol emerges at the next slot, OSR clocks later.
- FIFO full (count = 2) with sym_valid held high across a pop -> sym_ready is high for 1 cycle after the pop; exactly one push is accepted; count returns to 2; no data lost or duplicated (checked against a scoreboard).
- Assert reset mid-stream with count = 2 -> next cycle count = 0, out = 0, underflow = 0; previously buffered symbols never appear.
- Build with TX_SYMBOL_UPSAMPLER_HOLD_EN, push 10 then 01 -> out = +98304 for 4 clocks, then -32768 for 4 clocks.
